traffic_light_ctrl_timed: RTL and testbench

//   Two-road (A main, B side) traffic light controller with parametrised phase timers.

---
 rtl/traffic_light_ctrl_timed.sv | 169 ++++++++++++++++
 tb/tb_traffic_light_ctrl_timed.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_timed.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_timed
//   Two-road intersection controller (A = main road, B = side road) driven by a
//   single phase timer. Sequence: A green -> A yellow -> all-red -> B green
//   (or pedestrian walk) -> B yellow -> all-red -> A green. A level-sensitive
//   override forces flashing amber on both roads and returns via the
//   B->A all-red clearance.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   Sa_i / Sb_i    vehicle presence on road A / road B (level)
//   ped_req_i      pedestrian button, sampled every cycle
//   flash_i        flashing-amber override (level, highest priority)
//   Ga_o Ya_o Ra_o road A lamps
//   Gb_o Yb_o Rb_o road B lamps
//   walk_o         pedestrian walk lamp
//   ped_pending_o  pedestrian request latched and not yet served
//   state_o        current FSM state (debug)
// -----------------------------------------------------------------------------
module traffic_light_ctrl_timed #(
    parameter int CNT_W      = 8,
    parameter int GA_MIN     = 6,
    parameter int YEL_LEN    = 2,
    parameter int ALLRED_LEN = 1,
    parameter int GB_MIN     = 4,
    parameter int GB_MAX     = 12,
    parameter int WALK_LEN   = 5,
    parameter int FLASH_HALF = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Sa_i,
    input  logic       Sb_i,
    input  logic       ped_req_i,
    input  logic       flash_i,
    output logic       Ga_o,
    output logic       Ya_o,
    output logic       Ra_o,
    output logic       Gb_o,
    output logic       Yb_o,
    output logic       Rb_o,
    output logic       walk_o,
    output logic       ped_pending_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5,
        WALK  = 3'd6,
        FLASH = 3'd7
    } state_e;

    // Terminal counts: the timer holds the number of cycles already spent in
    // the phase, so a phase of N cycles ends when the timer reads N-1.
    localparam logic [CNT_W-1:0] GA_END     = CNT_W'(GA_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_END    = CNT_W'(YEL_LEN - 1);
    localparam logic [CNT_W-1:0] AR_END     = CNT_W'(ALLRED_LEN - 1);
    localparam logic [CNT_W-1:0] GBMIN_END  = CNT_W'(GB_MIN - 1);
    localparam logic [CNT_W-1:0] GBMAX_END  = CNT_W'(GB_MAX - 1);
    localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_LEN - 1);
    localparam logic [CNT_W-1:0] FLASH_END  = CNT_W'(FLASH_HALF - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pending_q, ped_pending_d;
    logic             phase_q, phase_d;
    logic             cnt_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= A_GRN;
            cnt_q         <= '0;
            ped_pending_q <= 1'b0;
            phase_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
            phase_q       <= phase_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_wrap = 1'b0;
        if (flash_i && (state_q != FLASH)) begin
            state_d = FLASH;
            phase_d = 1'b1;
        end else begin
            case (state_q)
                A_GRN: if ((cnt_q >= GA_END) && (Sb_i || ped_pending_q)) state_d = A_YEL;
                A_YEL: if (cnt_q == YEL_END) state_d = AR_AB;
                AR_AB: if (cnt_q == AR_END) state_d = ped_pending_q ? WALK : B_GRN;
                // Side road yields once its minimum is met and either road A
                // wants service or road B has emptied; the cap bounds B green.
                B_GRN: if (((cnt_q >= GBMIN_END) && (Sa_i || !Sb_i)) || (cnt_q == GBMAX_END))
                           state_d = B_YEL;
                B_YEL: if (cnt_q == YEL_END) state_d = AR_BA;
                AR_BA: if (cnt_q == AR_END) state_d = A_GRN;
                WALK:  if (cnt_q == WALK_END) state_d = Sb_i ? B_GRN : A_GRN;
                FLASH: begin
                    if (!flash_i) begin
                        state_d = AR_BA;
                    end else if (cnt_q == FLASH_END) begin
                        phase_d  = ~phase_q;
                        cnt_wrap = 1'b1;
                    end
                end
                default: state_d = AR_BA;
            endcase
        end
    end

    // Phase timer: restarts on any state change or flash half-period wrap,
    // otherwise counts up and sticks at all-ones (A green can dwell forever).
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || cnt_wrap) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pedestrian latch: entering WALK serves the request, including a press
    // arriving on that same edge; presses during WALK are ignored.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if ((state_d == WALK) && (state_q != WALK)) begin
            ped_pending_d = 1'b0;
        end else if (ped_req_i && (state_q != WALK)) begin
            ped_pending_d = 1'b1;
        end
    end

    // Moore lamp decode
    always_comb begin
        Ga_o   = 1'b0;
        Ya_o   = 1'b0;
        Ra_o   = 1'b0;
        Gb_o   = 1'b0;
        Yb_o   = 1'b0;
        Rb_o   = 1'b0;
        walk_o = 1'b0;
        case (state_q)
            A_GRN: begin Ga_o = 1'b1; Rb_o = 1'b1; end
            A_YEL: begin Ya_o = 1'b1; Rb_o = 1'b1; end
            B_GRN: begin Ra_o = 1'b1; Gb_o = 1'b1; end
            B_YEL: begin Ra_o = 1'b1; Yb_o = 1'b1; end
            AR_AB,
            AR_BA: begin Ra_o = 1'b1; Rb_o = 1'b1; end
            WALK:  begin Ra_o = 1'b1; Rb_o = 1'b1; walk_o = 1'b1; end
            FLASH: begin Ya_o = phase_q; Yb_o = phase_q; end
            default: begin Ra_o = 1'b1; Rb_o = 1'b1; end
        endcase
    end

    assign ped_pending_o = ped_pending_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl_timed
//   Directed vector table for the documented sequences, a hand-written
//   asynchronous reset check, and a randomized run against a phase-age model.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl_timed;

    localparam int GA_MIN     = 6;
    localparam int YEL_LEN    = 2;
    localparam int ALLRED_LEN = 1;
    localparam int GB_MIN     = 4;
    localparam int GB_MAX     = 12;
    localparam int WALK_LEN   = 5;
    localparam int FLASH_HALF = 3;

    // State numbers as reported on state_o
    localparam int S_AG = 0, S_AY = 1, S_AB = 2, S_BG = 3;
    localparam int S_BY = 4, S_BA = 5, S_WK = 6, S_FL = 7;

    // Lamp vectors {Ga,Ya,Ra,Gb,Yb,Rb,walk}
    localparam logic [6:0] L_AG  = 7'b1000010;
    localparam logic [6:0] L_AY  = 7'b0100010;
    localparam logic [6:0] L_AR  = 7'b0010010;
    localparam logic [6:0] L_BG  = 7'b0011000;
    localparam logic [6:0] L_BY  = 7'b0010100;
    localparam logic [6:0] L_WK  = 7'b0010011;
    localparam logic [6:0] L_FL1 = 7'b0100100;
    localparam logic [6:0] L_FL0 = 7'b0000000;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sa = 1'b0, sb = 1'b0, ped = 1'b0, fl = 1'b0;
    logic ga, ya, ra, gb, yb, rb, walk, pend;
    logic [2:0] st;
    logic [10:0] obs;

    always #5 clk = ~clk;

    traffic_light_ctrl_timed #(
        .CNT_W(8), .GA_MIN(GA_MIN), .YEL_LEN(YEL_LEN), .ALLRED_LEN(ALLRED_LEN),
        .GB_MIN(GB_MIN), .GB_MAX(GB_MAX), .WALK_LEN(WALK_LEN), .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .Sa_i(sa), .Sb_i(sb), .ped_req_i(ped), .flash_i(fl),
        .Ga_o(ga), .Ya_o(ya), .Ra_o(ra), .Gb_o(gb), .Yb_o(yb), .Rb_o(rb),
        .walk_o(walk), .ped_pending_o(pend), .state_o(st)
    );

    assign obs = {ga, ya, ra, gb, yb, rb, walk, pend, st};

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got lamps=%b pend=%b state=%0d, want lamps=%b pend=%b state=%0d",
                     name, act[10:4], act[3], act[2:0], exp[10:4], exp[3], exp[2:0]);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the phase by its 1-based age (which cycle of the phase we are in).
    int m_state;
    int m_age;
    bit m_pend;
    bit m_phase;

    function automatic void model_reset();
        m_state = S_AG;
        m_age   = 1;
        m_pend  = 1'b0;
        m_phase = 1'b1;
    endfunction

    function automatic logic [6:0] lamps_of(int s, bit ph);
        case (s)
            S_AG:       return L_AG;
            S_AY:       return L_AY;
            S_AB, S_BA: return L_AR;
            S_BG:       return L_BG;
            S_BY:       return L_BY;
            S_WK:       return L_WK;
            default:    return ph ? L_FL1 : L_FL0;
        endcase
    endfunction

    function automatic logic [10:0] model_out();
        return {lamps_of(m_state, m_phase), m_pend, 3'(m_state)};
    endfunction

    function automatic void model_step(bit a, bit b, bit p, bit f);
        int nxt     = m_state;
        bit nph     = m_phase;
        bit npend   = m_pend;
        bit restart = 1'b0;
        if (p && m_state != S_WK) npend = 1'b1;
        if (f && m_state != S_FL) begin
            nxt = S_FL;
            nph = 1'b1;
        end else begin
            case (m_state)
                S_AG: if (m_age >= GA_MIN && (b || m_pend)) nxt = S_AY;
                S_AY: if (m_age == YEL_LEN) nxt = S_AB;
                S_AB: if (m_age == ALLRED_LEN) nxt = m_pend ? S_WK : S_BG;
                S_BG: if ((m_age >= GB_MIN && (a || !b)) || m_age == GB_MAX) nxt = S_BY;
                S_BY: if (m_age == YEL_LEN) nxt = S_BA;
                S_BA: if (m_age == ALLRED_LEN) nxt = S_AG;
                S_WK: if (m_age == WALK_LEN) nxt = b ? S_BG : S_AG;
                default: begin
                    if (!f) nxt = S_BA;
                    else if (m_age == FLASH_HALF) begin
                        nph     = !m_phase;
                        restart = 1'b1;
                    end
                end
            endcase
        end
        if (nxt == S_WK && m_state != S_WK) npend = 1'b0;
        m_age   = (nxt != m_state || restart) ? 1 : m_age + 1;
        m_state = nxt;
        m_phase = nph;
        m_pend  = npend;
    endfunction

    // ---------------- driver tasks ----------------
    // Each cycle: inputs change just after the rising edge, outputs are
    // checked on the falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        sa = 1'b0; sb = 1'b0; ped = 1'b0; fl = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step_check(input string name, input logic [10:0] exp);
        @(negedge clk);
        check(name, obs, exp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst;
        bit         a, b, p, f;
        logic [2:0] st;
        bit         pend;
        logic [6:0] lamps;
        int         reps;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit a, input bit b, input bit p, input bit f,
                       input int s, input bit pd, input logic [6:0] l, input int n);
        vec_t v;
        v.rst = r; v.a = a; v.b = b; v.p = p; v.f = f;
        v.st = 3'(s); v.pend = pd; v.lamps = l; v.reps = n;
        tbl.push_back(v);
    endtask

    initial begin
        // idle after reset: A green holds
        add(1, 0, 0, 0, 0, S_AG, 0, L_AG, 50);
        // side-road demand from cycle 0, forced B-green cap, return to A
        add(1, 0, 1, 0, 0, S_AG, 0, L_AG, 6);
        add(0, 0, 1, 0, 0, S_AY, 0, L_AY, 2);
        add(0, 0, 1, 0, 0, S_AB, 0, L_AR, 1);
        add(0, 0, 1, 0, 0, S_BG, 0, L_BG, 12);
        add(0, 0, 1, 0, 0, S_BY, 0, L_BY, 2);
        add(0, 0, 1, 0, 0, S_BA, 0, L_AR, 1);
        add(0, 0, 1, 0, 0, S_AG, 0, L_AG, 6);
        add(0, 0, 1, 0, 0, S_AY, 0, L_AY, 1);
        // pedestrian pulse at cycle 2
        add(1, 0, 0, 0, 0, S_AG, 0, L_AG, 2);
        add(0, 0, 0, 1, 0, S_AG, 0, L_AG, 1);
        add(0, 0, 0, 0, 0, S_AG, 1, L_AG, 3);
        add(0, 0, 0, 0, 0, S_AY, 1, L_AY, 2);
        add(0, 0, 0, 0, 0, S_AB, 1, L_AR, 1);
        add(0, 0, 0, 0, 0, S_WK, 0, L_WK, 5);
        add(0, 0, 0, 0, 0, S_AG, 0, L_AG, 3);
        // flash override raised at B green cnt=2
        add(1, 0, 1, 0, 0, S_AG, 0, L_AG, 6);
        add(0, 0, 1, 0, 0, S_AY, 0, L_AY, 2);
        add(0, 0, 1, 0, 0, S_AB, 0, L_AR, 1);
        add(0, 0, 1, 0, 0, S_BG, 0, L_BG, 2);
        add(0, 0, 0, 0, 1, S_BG, 0, L_BG, 1);
        add(0, 0, 0, 0, 1, S_FL, 0, L_FL1, 3);
        add(0, 0, 0, 0, 1, S_FL, 0, L_FL0, 3);
        add(0, 0, 0, 0, 0, S_FL, 0, L_FL1, 1);
        add(0, 0, 0, 0, 0, S_BA, 0, L_AR, 1);
        add(0, 0, 0, 0, 0, S_AG, 0, L_AG, 2);

        // ---------- table pass ----------
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            for (int k = 0; k < tbl[i].reps; k++) begin
                sa = tbl[i].a; sb = tbl[i].b; ped = tbl[i].p; fl = tbl[i].f;
                step_check($sformatf("vec%0d_cyc%0d", i, k),
                           {tbl[i].lamps, tbl[i].pend, tbl[i].st});
            end
        end

        // ---------- asynchronous reset during B yellow ----------
        do_reset();
        sa = 1'b0; sb = 1'b1;
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        #2;
        check("byel_before_reset", obs, {L_BY, 1'b0, 3'(S_BY)});
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", obs, {L_AG, 1'b0, 3'(S_AG)});
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb = 1'b0;
        step_check("after_async_reset", {L_AG, 1'b0, 3'(S_AG)});

        // ---------- randomized run against the model ----------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 9) == 0)  sa = ~sa;
            if ($urandom_range(0, 9) == 0)  sb = ~sb;
            if ($urandom_range(0, 79) == 0) fl = ~fl;
            ped = ($urandom_range(0, 14) == 0);
            exp_q.push_back(model_out());
            @(negedge clk);
            check($sformatf("rand_cyc%0d", i), obs, exp_q.pop_front());
            model_step(sa, sb, ped, fl);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
